bus_transfer_ctrl: RTL and testbench
====================================

// Module: bus_transfer_ctrl
// PURPOSE
//  Sequencer driving the W (write) and RE (output-disable) strobes of a bank of
//  16-bit level-sensitive bus registers sharing one tri-state data bus.
//  Executes register-to-register moves: src drives bus, dst latches, bus released.
//  Guarantees at most one driver on the bus at any time. Sits between decode and register file.
// PARAMETERS
//  NREGS   8   number of registers on the bus (power of 2, 2..16)
//  DATA_W  16  bus width
//  SEL_W   3   select width, log2(NREGS)
// PORTS
//  CLK      in   1       system clock, rising edge
//  RST_N    in   1       asynchronous active-low reset
//  REQ      in   1       transfer request, level; sampled only in IDLE
//  SRC      in   SEL_W   source register index, sampled with REQ
//  DST      in   SEL_W   destination register index, sampled with REQ
//  BUS      in   DATA_W  shared bus, observed for capture only
//  ACK      out  1       one-cycle pulse: request accepted
//  ERR      out  1       one-cycle pulse: request rejected (SRC==DST)
//  BUSY     out  1       high from accept to end of RELEASE
//  DONE     out  1       one-cycle pulse in RELEASE
//  W        out  NREGS   per-register write strobe, one-hot or zero
//  RE       out  NREGS   per-register output disable; 1 = tri-state, one-cold or all-ones
//  LAST     out  DATA_W  bus value captured at end of WRITE
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE; W=0, RE=all-ones, ACK/ERR/DONE/BUSY=0, LAST=0.
//   Applies mid-transfer immediately, without waiting for CLK; no partial write completes after reset.
//  FSM states, one cycle each unless noted: IDLE, DRIVE, WRITE, HOLD, RELEASE.
//  IDLE: W=0, RE=all-ones. On REQ=1 at an edge:
//   - SRC!=DST: latch SRC/DST; ACK=1 next cycle; go DRIVE.
//   - SRC==DST: ERR=1 next cycle; stay IDLE; no strobe moves.
//  DRIVE: RE[src]=0, W=0. Bus settles.
//  WRITE: RE[src]=0, W[dst]=1. At the end of the cycle, LAST <= BUS.
//  HOLD: RE[src]=0, W=0. Data stays valid across the falling edge of W (hold margin).
//  RELEASE: RE=all-ones, W=0, DONE=1. This is the bus turnaround cycle; go IDLE.
//  Latency: accept edge -> DONE is 4 cycles. Back-to-back max rate is 1 transfer per 5 cycles.
//  REQ held high remains pending; it is re-sampled in IDLE after RELEASE.
//  Invariants, every cycle: popcount(~RE)<=1; popcount(W)<=1; W[i] and ~RE[i] never both set.
//   W is only asserted while exactly one RE is low.
//  SRC/DST changes after accept are ignored; the latched copies are used.
//  Index >= NREGS (non-power-of-2 NREGS excluded by parameter rule): not applicable.
//  All outputs are registered (decoded from registered state and latched indices).
// STRUCTURE
//  Include file bus_ctrl_defs.vh: state encodings (IDLE=0..RELEASE=4), width constants.
//  One sub-module, onehot_dec (SEL_W -> NREGS, with enable).
//   Used twice: W = onehot_dec(dst, en_w); RE = ~onehot_dec(src, en_drv).
// TESTING (bench instantiates NREGS bus registers plus this block)
//  1 Reset: hold RST_N=0 -> W=00, RE=FF, BUSY=0. Release, then REQ SRC=2 DST=5 with
//    reg2=A5A5 -> ACK; after 4 cycles DONE; reg5=A5A5, LAST=A5A5.
//  2 SRC=3 DST=3, REQ -> ERR pulse, no ACK, W=00, RE=FF for the whole window.
//  3 Back-to-back, REQ held: 0->1 then 1->7 with reg0=1234 -> reg1=1234, reg7=1234.
//    DONE spacing is 5 cycles.
//  4 Assert RST_N=0 during WRITE of 4->6 (reg6=0000, reg4=FFFF) -> W/RE return to
//    00/FF in the same delta, without a clock. Next transfer then runs normally.
//  5 Change SRC/DST during DRIVE (2->3 becomes 0->1) -> reg3 receives reg2; reg1 unchanged.
//  6 Random 10000 transfers with assertions: one bus driver at most, no W without a
//    driver, contents match a reference model, bus never X while W is asserted.

Source files
------------

// File: rtl/bus_transfer_ctrl_pkg.sv
// rtl/bus_transfer_ctrl_pkg.sv - shared types and defaults for the bus transfer sequencer
//
// Purpose : FSM state encoding and default geometry of the register bus.
//           The state encodings are fixed (IDLE=0 .. RELEASE=4) so that debug
//           probes and waveform decoders can rely on them.
package bus_transfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam int DEF_NREGS  = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SEL_W  = 3;

endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// rtl/bus_transfer_ctrl_if.sv - request/strobe bundle between decode, sequencer and register bank
//
// Purpose : groups the transfer request, status pulses and register-bank
//           strobes of one shared bus.
// Signals : req/src/dst  transfer request and register indices (decode side)
//           bus          shared data bus as seen by the sequencer
//           ack/err/done one-cycle status pulses, busy level
//           w/re         per-register write strobe / output disable
//           last         bus value captured during the last write
// Modports: master = requester + register bank, slave = sequencer
interface bus_transfer_ctrl_if
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
);
    logic              req;
    logic [SEL_W-1:0]  src;
    logic [SEL_W-1:0]  dst;
    logic [DATA_W-1:0] bus;
    logic              ack;
    logic              err;
    logic              busy;
    logic              done;
    logic [NREGS-1:0]  w;
    logic [NREGS-1:0]  re;
    logic [DATA_W-1:0] last;

    modport master (
        output req, src, dst, bus,
        input  ack, err, busy, done, w, re, last
    );

    modport slave (
        input  req, src, dst, bus,
        output ack, err, busy, done, w, re, last
    );
endinterface

// File: rtl/bus_transfer_ctrl_onehot_dec.sv
// rtl/bus_transfer_ctrl_onehot_dec.sv - index to one-hot decoder with enable
//
// Purpose : dec has exactly one bit set (bit sel) when en=1, all zero otherwise.
// Ports   : sel  in  SEL_W  index
//           en   in  1      enable
//           dec  out N      one-hot result
module onehot_dec #(
    parameter int SEL_W = 3,
    parameter int N     = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     dec
);
    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++) begin
            dec[i] = en && (sel == SEL_W'(i));
        end
    end
endmodule

// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - sequencer for register-to-register moves over a shared tri-state bus
//
// Purpose : runs IDLE -> DRIVE -> WRITE -> HOLD -> RELEASE for each accepted
//           move so the source drives the bus before the destination latches
//           and keeps driving past the falling edge of W; RELEASE is the bus
//           turnaround cycle so two sources never overlap.
// Ports   : clk    in  system clock, rising edge
//           rst_n  in  asynchronous active-low reset
//           bif    slave modport of bus_transfer_ctrl_if
module bus_transfer_ctrl
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_transfer_ctrl_if.slave  bif
);
    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  src_q;
    logic [SEL_W-1:0]  dst_q;
    logic [DATA_W-1:0] last_q;
    logic              ack_q;
    logic              err_q;
    logic              accept;
    logic              reject;
    logic              en_w;
    logic              en_drv;
    logic [NREGS-1:0]  w_dec;
    logic [NREGS-1:0]  drv_dec;

    // Requests are only looked at in IDLE; a held req is simply seen again
    // once the sequencer returns there.
    assign accept = (state == ST_IDLE) && bif.req && (bif.src != bif.dst);
    assign reject = (state == ST_IDLE) && bif.req && (bif.src == bif.dst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE:   state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = ST_HOLD;
            ST_HOLD:    state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Indices are frozen at accept so later changes on src/dst cannot move
    // the driver or the write target mid-transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            last_q <= '0;
        end else begin
            ack_q <= accept;
            err_q <= reject;
            if (accept) begin
                src_q <= bif.src;
                dst_q <= bif.dst;
            end
            if (state == ST_WRITE) begin
                last_q <= bif.bus;
            end
        end
    end

    // Strobes decode straight from the registered state, so the async reset
    // of the state register drops W and releases the bus without a clock.
    assign en_w   = (state == ST_WRITE);
    assign en_drv = (state == ST_DRIVE) || (state == ST_WRITE) || (state == ST_HOLD);

    onehot_dec #(.SEL_W(SEL_W), .N(NREGS)) u_w_dec (
        .sel (dst_q),
        .en  (en_w),
        .dec (w_dec)
    );

    onehot_dec #(.SEL_W(SEL_W), .N(NREGS)) u_drv_dec (
        .sel (src_q),
        .en  (en_drv),
        .dec (drv_dec)
    );

    assign bif.w    = w_dec;
    assign bif.re   = ~drv_dec;
    assign bif.ack  = ack_q;
    assign bif.err  = err_q;
    assign bif.busy = (state != ST_IDLE);
    assign bif.done = (state == ST_RELEASE);
    assign bif.last = last_q;
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - self-checking bench with a model register bank on the bus
module tb_bus_transfer_ctrl;
    localparam int NREGS = 8;
    localparam int DW    = 16;
    localparam int SW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_transfer_ctrl_if #(.NREGS(NREGS), .DATA_W(DW), .SEL_W(SW)) bif ();

    bus_transfer_ctrl #(.NREGS(NREGS), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    // Register bank: enabled source drives the bus, W captures at the clock edge.
    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] mdl  [NREGS];
    logic [DW-1:0] bus_drv;
    logic          ld_en;
    logic [SW-1:0] ld_idx;
    logic [DW-1:0] ld_val;

    always_comb begin
        bus_drv = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (!bif.re[i]) bus_drv = bus_drv | regs[i];
        end
    end
    assign bif.bus = bus_drv;

    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (bif.w[i]) regs[i] <= bif.bus;
        end
        if (ld_en) regs[ld_idx] <= ld_val;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus safety checked every cycle, away from the active edge.
    always @(negedge clk) begin
        check("bus_invariant",
              {31'd0, ($countones(~bif.re) <= 1) && ($countones(bif.w) <= 1) &&
                      ((bif.w & ~bif.re) == '0) &&
                      ((bif.w == '0) || ($countones(~bif.re) == 1)) &&
                      !((bif.w != '0) && $isunknown(bif.bus))},
              32'd1);
    end

    task automatic load(input logic [SW-1:0] idx, input logic [DW-1:0] v);
        ld_en = 1'b1; ld_idx = idx; ld_val = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
        mdl[idx] = v;
    endtask

    task automatic xfer(input logic [SW-1:0] s, input logic [SW-1:0] d, input string nm);
        int k;
        logic [DW-1:0] exp_val;
        exp_val = mdl[s];
        bif.req = 1'b1; bif.src = s; bif.dst = d;
        @(posedge clk); #1;
        bif.req = 1'b0;
        if (s == d) begin
            check({nm, "_err"},   {31'd0, bif.err}, 32'd1);
            check({nm, "_noack"}, {31'd0, bif.ack}, 32'd0);
            for (int c = 0; c < 4; c++) begin
                check({nm, "_quiet"}, {15'd0, bif.busy, bif.w, bif.re}, {15'd0, 1'b0, 8'h00, 8'hFF});
                @(posedge clk); #1;
            end
            check({nm, "_errpulse"}, {31'd0, bif.err}, 32'd0);
        end else begin
            check({nm, "_ack"},  {31'd0, bif.ack}, 32'd1);
            check({nm, "_busy"}, {31'd0, bif.busy}, 32'd1);
            k = 0;
            while (!bif.done && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            check({nm, "_latency"}, k, 32'd3);
            @(posedge clk); #1;
            check({nm, "_idle"}, {31'd0, bif.busy}, 32'd0);
            check({nm, "_dst"},  {16'd0, regs[d]}, {16'd0, exp_val});
            check({nm, "_last"}, {16'd0, bif.last}, {16'd0, exp_val});
            mdl[d] = exp_val;
        end
    endtask

    typedef struct {
        logic [SW-1:0] src;
        logic [SW-1:0] dst;
        logic [DW-1:0] sval;
        logic [DW-1:0] dval;
        logic [DW-1:0] exp_dst;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int d1, d2;
        vecs[0] = '{3'd2, 3'd5, 16'hA5A5, 16'h0000, 16'hA5A5};
        vecs[1] = '{3'd3, 3'd3, 16'h1111, 16'h1111, 16'h1111};
        vecs[2] = '{3'd7, 3'd0, 16'hBEEF, 16'h0001, 16'hBEEF};
        vecs[3] = '{3'd0, 3'd7, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[4] = '{3'd6, 3'd1, 16'h5A5A, 16'hC3C3, 16'h5A5A};
        vecs[5] = '{3'd1, 3'd6, 16'h8001, 16'h7FFE, 16'h8001};

        rst_n = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_val = '0;
        bif.req = 1'b0; bif.src = '0; bif.dst = '0;
        #1;
        check("rst_w",    {24'd0, bif.w}, 32'h00);
        check("rst_re",   {24'd0, bif.re}, 32'hFF);
        check("rst_flag", {28'd0, bif.busy, bif.ack, bif.err, bif.done}, 32'd0);
        check("rst_last", {16'd0, bif.last}, 32'd0);
        for (int i = 0; i < NREGS; i++) load(SW'(i), 16'h0000);
        bif.req = 1'b1; bif.src = 3'd1; bif.dst = 3'd2;
        @(posedge clk); #1;
        check("rst_ignores_req", {15'd0, bif.busy, bif.w, bif.re}, {15'd0, 1'b0, 8'h00, 8'hFF});
        bif.req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven moves, including SRC==DST rejection and index extremes.
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].src, vecs[v].sval);
            if (vecs[v].dst != vecs[v].src) load(vecs[v].dst, vecs[v].dval);
            xfer(vecs[v].src, vecs[v].dst, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_result", v), {16'd0, regs[vecs[v].dst]}, {16'd0, vecs[v].exp_dst});
        end

        // Back-to-back with req held; src/dst changed right after the first accept.
        load(3'd0, 16'h1234); load(3'd1, 16'h0000); load(3'd7, 16'h0000);
        bif.req = 1'b1; bif.src = 3'd0; bif.dst = 3'd1;
        @(posedge clk); #1;
        check("b2b_ack", {31'd0, bif.ack}, 32'd1);
        bif.src = 3'd1; bif.dst = 3'd7;
        d1 = -1; d2 = -1;
        for (int c = 0; c < 20 && d2 < 0; c++) begin
            if (bif.done) begin
                if (d1 < 0) d1 = cyc; else d2 = cyc;
            end
            @(posedge clk); #1;
        end
        bif.req = 1'b0;
        check("b2b_spacing", d2 - d1, 32'd5);
        @(posedge clk); #1;
        check("b2b_idle", {31'd0, bif.busy}, 32'd0);
        check("b2b_reg1", {16'd0, regs[1]}, 32'h1234);
        check("b2b_reg7", {16'd0, regs[7]}, 32'h1234);
        mdl[1] = 16'h1234; mdl[7] = 16'h1234;

        // Asynchronous reset in the middle of WRITE.
        load(3'd4, 16'hFFFF); load(3'd6, 16'h0000);
        bif.req = 1'b1; bif.src = 3'd4; bif.dst = 3'd6;
        @(posedge clk); #1;
        bif.req = 1'b0;
        @(posedge clk); #1;
        check("rw_in_write", {24'd0, bif.w}, 32'h40);
        #2 rst_n = 1'b0;
        #1;
        check("rw_w_async",  {24'd0, bif.w}, 32'h00);
        check("rw_re_async", {24'd0, bif.re}, 32'hFF);
        check("rw_busy",     {31'd0, bif.busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rw_no_write", {16'd0, regs[6]}, 32'h0000);
        @(posedge clk); #1;
        xfer(3'd4, 3'd6, "rw_after");

        // Indices changed during DRIVE must not redirect the move.
        load(3'd0, 16'h0A0A); load(3'd1, 16'h1111);
        load(3'd2, 16'h2222); load(3'd3, 16'h3333);
        bif.req = 1'b1; bif.src = 3'd2; bif.dst = 3'd3;
        @(posedge clk); #1;
        bif.req = 1'b0; bif.src = 3'd0; bif.dst = 3'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        check("chg_reg3", {16'd0, regs[3]}, 32'h2222);
        check("chg_reg1", {16'd0, regs[1]}, 32'h1111);
        mdl[3] = 16'h2222;

        // Random moves against the reference contents.
        for (int n = 0; n < 10000; n++) begin
            if (n % 16 == 0) load(SW'($urandom_range(NREGS - 1)), DW'($urandom));
            xfer(SW'($urandom_range(NREGS - 1)), SW'($urandom_range(NREGS - 1)), "rnd");
        end
        for (int i = 0; i < NREGS; i++) begin
            check($sformatf("final_reg%0d", i), {16'd0, regs[i]}, {16'd0, mdl[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
